wb_commit_buffer: RTL and testbench

In-order writeback buffer that sits between the execution units and the architectural register file, on the write side of the regfile interface. Issue allocates one entry per instruction with its destination register. Execution units complete entries out of order with result data. Each cycle the buffer retires up to WRITE_PORTS oldest completed entries, in order, onto the regfile write ports (valid/wa/wd).

---
 rtl/common_pkg.sv | 18 +
 rtl/wb_commit_select.sv | 25 ++
 rtl/wb_commit_buffer.sv | 128 ++++++++++++
 tb/tb_wb_commit_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types for the writeback path: register addresses, ROB tags and entries.
package common;

  localparam int ROB_DEPTH        = 8;
  localparam int AREG_WRITE_PORTS = 2;

  typedef logic [63:0]                  u64;
  typedef logic [4:0]                   creg_addr_t;
  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_tag_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    creg_addr_t dst;
    u64         data;
  } rob_entry_t;

endpackage

// File: rtl/wb_commit_select.sv
// In-order retire selection: a candidate retires only if every older candidate retires too.
module wb_commit_select #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  done_ok_i,
  output logic [N-1:0]  retire_mask_o,
  output logic [CW-1:0] retire_cnt_o
);

  logic run;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    run           = 1'b1;
    retire_mask_o = '0;
    retire_cnt_o  = '0;
    for (int k = 0; k < N; k++) begin
      run              = run & done_ok_i[k];
      retire_mask_o[k] = run;
      retire_cnt_o     = retire_cnt_o + CW'(run);
    end
  end

endmodule

// File: rtl/wb_commit_buffer.sv
// In-order writeback buffer: allocate at issue, complete out of order, retire the
// oldest completed prefix onto the regfile write ports each cycle.
module wb_commit_buffer
  import common::*;
#(
  parameter int DEPTH       = ROB_DEPTH,
  parameter int WRITE_PORTS = AREG_WRITE_PORTS,
  parameter int CMPL_PORTS  = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      alloc_valid,
  input  creg_addr_t                                alloc_dst,
  output logic                                      alloc_ready,
  output logic [$clog2(DEPTH)-1:0]                  alloc_tag,
  input  logic [CMPL_PORTS-1:0]                     cmpl_valid,
  input  logic [CMPL_PORTS-1:0][$clog2(DEPTH)-1:0]  cmpl_tag,
  input  logic [CMPL_PORTS-1:0][63:0]               cmpl_data,
  input  logic                                      flush,
  output logic [WRITE_PORTS-1:0]                    wb_valid,
  output logic [WRITE_PORTS-1:0][4:0]               wb_wa,
  output logic [WRITE_PORTS-1:0][63:0]              wb_wd,
  output logic [$clog2(DEPTH):0]                    count,
  output logic                                      empty
);

  localparam int TW  = $clog2(DEPTH);
  localparam int PW  = TW + 1;
  localparam int RCW = $clog2(WRITE_PORTS + 1);

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d;
  creg_addr_t       dst_q  [DEPTH];
  u64               data_q [DEPTH];

  logic                   alloc_fire;
  logic [TW-1:0]          head_idx, tail_idx;
  logic [TW-1:0]          cand_idx [WRITE_PORTS];
  rob_entry_t             cand     [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] cand_ok, retire_mask;
  logic [RCW-1:0]         retire_cnt;

  assign head_idx    = head_q[TW-1:0];
  assign tail_idx    = tail_q[TW-1:0];
  assign count       = tail_q - head_q;
  assign empty       = (count == '0);
  // Gating with reset keeps issue blocked for the whole time reset is held.
  assign alloc_ready = reset && !flush && (count < PW'(DEPTH));
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;

  always_comb begin
    for (int k = 0; k < WRITE_PORTS; k++) begin
      cand_idx[k] = head_idx + TW'(k);
      cand[k]     = '{busy: busy_q[cand_idx[k]], done: done_q[cand_idx[k]],
                      dst: dst_q[cand_idx[k]], data: data_q[cand_idx[k]]};
      cand_ok[k]  = cand[k].busy && cand[k].done && !flush;
    end
  end

  wb_commit_select #(.N(WRITE_PORTS), .CW(RCW)) u_select (
    .done_ok_i     (cand_ok),
    .retire_mask_o (retire_mask),
    .retire_cnt_o  (retire_cnt)
  );

  // x0 entries retire silently; idle ports drive zeros rather than stale payload.
  always_comb begin
    for (int k = 0; k < WRITE_PORTS; k++) begin
      wb_valid[k] = retire_mask[k] && (cand[k].dst != '0);
      wb_wa[k]    = wb_valid[k] ? cand[k].dst  : '0;
      wb_wd[k]    = wb_valid[k] ? cand[k].data : '0;
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      busy_d = '0;
      done_d = '0;
      head_d = '0;
      tail_d = '0;
    end else begin
      for (int p = 0; p < CMPL_PORTS; p++)
        if (cmpl_valid[p] && busy_q[cmpl_tag[p]]) done_d[cmpl_tag[p]] = 1'b1;
      for (int k = 0; k < WRITE_PORTS; k++)
        if (retire_mask[k]) begin
          busy_d[cand_idx[k]] = 1'b0;
          done_d[cand_idx[k]] = 1'b0;
        end
      if (alloc_fire) begin
        busy_d[tail_idx] = 1'b1;
        done_d[tail_idx] = 1'b0;
        tail_d           = tail_q + PW'(1);
      end
      head_d = head_q + PW'(retire_cnt);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // NOTE: payload storage has no reset; busy/done gate every use, so stale contents never escape.
  // Later completion ports are written last, so the higher port wins a shared tag.
  always_ff @(posedge clk) begin
    if (alloc_fire) dst_q[tail_idx] <= alloc_dst;
    if (!flush) begin
      for (int p = 0; p < CMPL_PORTS; p++)
        if (cmpl_valid[p] && busy_q[cmpl_tag[p]]) data_q[cmpl_tag[p]] <= cmpl_data[p];
    end
  end

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Randomized and directed bench for wb_commit_buffer against an age-ordered queue model.
module tb_wb_commit_buffer;
  import common::*;

  localparam int DEPTH = 8;
  localparam int WP    = 2;
  localparam int CP    = 2;
  localparam int TW    = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   alloc_valid;
  logic [4:0]             alloc_dst;
  logic                   alloc_ready;
  logic [TW-1:0]          alloc_tag;
  logic [CP-1:0]          cmpl_valid;
  logic [CP-1:0][TW-1:0]  cmpl_tag;
  logic [CP-1:0][63:0]    cmpl_data;
  logic                   flush;
  logic [WP-1:0]          wb_valid;
  logic [WP-1:0][4:0]     wb_wa;
  logic [WP-1:0][63:0]    wb_wd;
  logic [TW:0]            count;
  logic                   empty;

  always #5 clk = ~clk;

  wb_commit_buffer #(.DEPTH(DEPTH), .WRITE_PORTS(WP), .CMPL_PORTS(CP)) dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_valid (alloc_valid),
    .alloc_dst   (alloc_dst),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cmpl_valid  (cmpl_valid),
    .cmpl_tag    (cmpl_tag),
    .cmpl_data   (cmpl_data),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_wa       (wb_wa),
    .wb_wd       (wb_wd),
    .count       (count),
    .empty       (empty)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of live tags in age order plus per-tag payload.
  int         mq[$];
  bit         m_done [DEPTH];
  logic [4:0] m_dst  [DEPTH];
  logic [63:0] m_data[DEPTH];
  int         m_next;

  function automatic bit m_busy(input int t);
    foreach (mq[i]) if (mq[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_next = 0;
    for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_dst   = '0;
    cmpl_valid  = '0;
    cmpl_tag    = '0;
    cmpl_data   = '0;
    flush       = 1'b0;
  endtask

  task automatic set_cmpl(input int p, input int t, input logic [63:0] d);
    cmpl_valid[p] = 1'b1;
    cmpl_tag[p]   = TW'(t);
    cmpl_data[p]  = d;
  endtask

  // Called at a negedge with inputs set: check outputs, advance model over the edge.
  task automatic tick();
    logic [WP-1:0] ev;
    logic [4:0]    ewa [WP];
    logic [63:0]   ewd [WP];
    bit            e_ready;
    int            e_nret;
    int            t;
    #1;
    e_ready = (mq.size() < DEPTH) && !flush;
    e_nret  = 0;
    ev      = '0;
    for (int k = 0; k < WP; k++) begin
      ewa[k] = '0;
      ewd[k] = '0;
    end
    if (!flush) begin
      while (e_nret < WP && e_nret < mq.size() && m_done[mq[e_nret]]) begin
        t = mq[e_nret];
        if (m_dst[t] != 0) begin
          ev[e_nret]  = 1'b1;
          ewa[e_nret] = m_dst[t];
          ewd[e_nret] = m_data[t];
        end
        e_nret++;
      end
    end
    check("alloc_ready", 64'(alloc_ready), 64'(e_ready));
    check("alloc_tag", 64'(alloc_tag), 64'(m_next));
    check("count", 64'(count), 64'(mq.size()));
    check("empty", 64'(empty), 64'(mq.size() == 0));
    check("wb_valid", 64'(wb_valid), 64'(ev));
    for (int k = 0; k < WP; k++) begin
      check($sformatf("wb_wa%0d", k), 64'(wb_wa[k]), 64'(ewa[k]));
      check($sformatf("wb_wd%0d", k), wb_wd[k], ewd[k]);
    end
    @(posedge clk);
    if (flush) model_reset();
    else begin
      for (int p = 0; p < CP; p++) begin
        t = int'(cmpl_tag[p]);
        if (cmpl_valid[p] && m_busy(t)) begin
          m_done[t] = 1'b1;
          m_data[t] = cmpl_data[p];
        end
      end
      repeat (e_nret) begin
        m_done[mq[0]] = 1'b0;
        void'(mq.pop_front());
      end
      if (alloc_valid && e_ready) begin
        mq.push_back(m_next);
        m_dst[m_next]  = alloc_dst;
        m_done[m_next] = 1'b0;
        m_next         = (m_next + 1) % DEPTH;
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic alloc(input logic [4:0] d);
    alloc_valid = 1'b1;
    alloc_dst   = d;
    tick();
  endtask

  task automatic drain();
    int pend[$];
    foreach (mq[i]) if (!m_done[mq[i]]) pend.push_back(mq[i]);
    while (pend.size() > 0) begin
      for (int p = 0; p < CP && pend.size() > 0; p++)
        set_cmpl(p, pend.pop_front(), {$urandom, $urandom});
      tick();
    end
    for (int i = 0; i < 20 && mq.size() > 0; i++) tick();
    check("drain_empty", 64'(empty), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    idle();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_ready", 64'(alloc_ready), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_wbv", 64'(wb_valid), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Burst: three allocs, completions on consecutive cycles.
    alloc(5); alloc(6); alloc(7);
    set_cmpl(0, 0, 64'hA); set_cmpl(1, 1, 64'hB);
    tick();
    set_cmpl(0, 2, 64'hC);
    #1;
    check("s1_wa0", 64'(wb_wa[0]), 64'(5));
    check("s1_wd0", wb_wd[0], 64'hA);
    check("s1_wa1", 64'(wb_wa[1]), 64'(6));
    check("s1_wd1", wb_wd[1], 64'hB);
    tick();
    #1;
    check("s1_wbv_p0", 64'(wb_valid), 64'(2'b01));
    check("s1_wa0_c", 64'(wb_wa[0]), 64'(7));
    check("s1_wd0_c", wb_wd[0], 64'hC);
    tick();
    #1 check("s1_empty", 64'(empty), 64'(1));

    // Out-of-order completion: younger done first must wait.
    alloc(1); alloc(2);
    set_cmpl(0, 4, 64'h22);
    tick();
    tick();
    #1 check("ooo_hold", 64'(wb_valid), 64'(0));
    set_cmpl(0, 3, 64'h11);
    tick();
    #1;
    check("ooo_wbv", 64'(wb_valid), 64'(2'b11));
    check("ooo_wa0", 64'(wb_wa[0]), 64'(1));
    check("ooo_wa1", 64'(wb_wa[1]), 64'(2));
    tick();

    // Full buffer and pointer wrap.
    flush = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1));
    #1;
    check("full_count", 64'(count), 64'(8));
    check("full_ready", 64'(alloc_ready), 64'(0));
    alloc(20);
    set_cmpl(0, 0, 64'h100);
    tick();
    #1;
    check("full_commit", 64'(wb_valid), 64'(2'b01));
    check("full_still_blocked", 64'(alloc_ready), 64'(0));
    tick();
    #1;
    check("full_reopen", 64'(alloc_ready), 64'(1));
    check("wrap_tag0", 64'(alloc_tag), 64'(0));
    alloc(21);
    set_cmpl(0, 1, 64'h101);
    tick();
    tick();
    #1 check("wrap_tag1", 64'(alloc_tag), 64'(1));
    alloc(22);
    drain();

    // Same destination twice, then an x0 entry.
    t = m_next;
    alloc(3); alloc(3); alloc(0);
    set_cmpl(0, t, 64'h111); set_cmpl(1, (t + 1) % DEPTH, 64'h222);
    tick();
    set_cmpl(0, (t + 2) % DEPTH, 64'h333);
    #1;
    check("dup_wbv", 64'(wb_valid), 64'(2'b11));
    check("dup_wa1", 64'(wb_wa[1]), 64'(3));
    check("dup_wd1_younger", wb_wd[1], 64'h222);
    tick();
    #1;
    check("x0_silent", 64'(wb_valid), 64'(0));
    check("x0_count", 64'(count), 64'(1));
    tick();
    #1 check("x0_retired", 64'(count), 64'(0));

    // Flush with retirable head plus same-cycle alloc and completion.
    t = m_next;
    for (int i = 0; i < 4; i++) alloc(5'(10 + i));
    set_cmpl(0, t, 64'h55); set_cmpl(1, (t + 1) % DEPTH, 64'h66);
    tick();
    flush = 1'b1; alloc_valid = 1'b1; alloc_dst = 5'd9;
    set_cmpl(0, (t + 2) % DEPTH, 64'h77);
    #1 check("flush_wbv", 64'(wb_valid), 64'(0));
    tick();
    #1;
    check("flush_count", 64'(count), 64'(0));
    check("flush_tag", 64'(alloc_tag), 64'(0));
    set_cmpl(0, 1, 64'hDEAD);
    tick();
    tick();

    // Asynchronous reset mid-burst.
    alloc(4); alloc(5);
    set_cmpl(0, 0, 64'h44); set_cmpl(1, 1, 64'h45);
    tick();
    #2 reset = 1'b0;
    #1;
    check("arst_wbv", 64'(wb_valid), 64'(0));
    check("arst_count", 64'(count), 64'(0));
    check("arst_empty", 64'(empty), 64'(1));
    check("arst_ready", 64'(alloc_ready), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1 check("arst_tag0", 64'(alloc_tag), 64'(0));
    alloc(8);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(99) < 60) begin
        alloc_valid = 1'b1;
        alloc_dst   = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(7));
      end
      for (int p = 0; p < CP; p++) begin
        if ($urandom_range(99) < 50) begin
          if (mq.size() > 0 && $urandom_range(99) < 85)
            t = mq[$urandom_range(mq.size() - 1)];
          else
            t = int'($urandom_range(DEPTH - 1));
          set_cmpl(p, t, {$urandom, $urandom});
        end
      end
      if ($urandom_range(99) < 2) flush = 1'b1;
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
